piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out front end of the serial shift chain. Accepts a WIDTH-bit
//   word over a valid/ready handshake, emits it one bit per clk on dout, which feeds
//   the downstream serial-in shift stage. Supports gapless back-to-back words.
// PARAMETERS
//   WIDTH      8   data word width, >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      block can accept a word this cycle
//   load_data   in   WIDTH  parallel word
//   dout        out  1      serial bit, drives downstream serial input
//   dout_valid  out  1      dout carries a live bit
//   dout_last   out  1      dout is the final bit of the current frame
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, shift reg=0, bit count=0, dout=0,
//     dout_valid=0, dout_last=0. load_ready=1 once rst_n is high.
//   - FSM: IDLE, SHIFT. IDLE->SHIFT on accept. SHIFT->IDLE after the final bit
//     unless a new word is accepted that cycle (then stays in SHIFT).
//   - Accept = load_valid && load_ready at posedge clk. load_ready is combinational:
//     1 in IDLE, 1 in SHIFT only on the final-bit cycle, else 0.
//   - Latency: first bit on dout in the cycle after accept; frame = FRAME_LEN
//     consecutive cycles with dout_valid=1 (FRAME_LEN = WIDTH, or WIDTH+1 with parity).
//   - dout, dout_valid, dout_last are registered. dout_last=1 only on final bit.
//   - Back-to-back: accept on final-bit cycle -> next word's first bit follows with
//     no idle cycle; dout_valid stays 1.
//   - load_valid while load_ready=0: ignored, load_data not sampled, no stall.
//   - Idle: dout=0, dout_valid=0 (line parks low).
//   - Bit counter counts 0..FRAME_LEN-1, wraps to 0 on frame end; width $clog2(WIDTH+1).
//   - Reset mid-frame: frame dropped, outputs to reset values immediately.
// CONFIGURATION
//   PISO_PARITY_EN defined: one even-parity bit (XOR of the WIDTH data bits) appended
//     after the data bits; dout_last moves to the parity bit; FRAME_LEN=WIDTH+1.
//   PISO_PARITY_EN undefined: no parity logic; FRAME_LEN=WIDTH.
// STRUCTURE
//   Shared package serial_pkg: FSM state encoding (IDLE=1'b0, SHIFT=1'b1), default
//   WIDTH constant, parity-function helper used by serializer and deserializer.
//   One sub-module: serial_bit_counter (enable, clear, terminal-count flag, param
//   MAX) instantiated once; FSM and shift register stay in this module.
// TESTING
//   1 Reset release, no load 10 cycles -> dout=0, dout_valid=0, load_ready=1 throughout.
//   2 WIDTH=8 MSB_FIRST=1, load 8'hA5 -> dout 1,0,1,0,0,1,0,1 in cycles 1..8 after
//     accept; dout_last=1 in cycle 8 only; load_ready=0 cycles 1..7.
//   3 MSB_FIRST=0, load 8'hA5 then 8'h3C on final-bit cycle -> 1,0,1,0,0,1,0,1,
//     0,0,1,1,1,1,0,0 over 16 contiguous dout_valid cycles.
//   4 Load 8'hFF, pulse load_valid with 8'h00 at cycle 3 -> ignored, eight 1s emitted.
//   5 Load 8'hA5, assert rst_n=0 at cycle 4 -> outputs zero same cycle; after
//     release load 8'h01 -> clean frame 0,0,0,0,0,0,0,1.
//   6 PISO_PARITY_EN, load 8'h07 -> 0,0,0,0,0,1,1,1 then parity 1; dout_last on bit 9.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift chain (serializer and deserializer):
// FSM state encoding, default word width and the even-parity helper.
package serial_pkg;

    // Two-state framing FSM shared by both ends of the chain
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Widest word the parity helper accepts; callers zero-extend narrower words,
    // which leaves the XOR unchanged.
    localparam int PARITY_MAX_W = 64;

    // Even parity: XOR of all data bits, so data plus parity has an even count of ones
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for serial framing. Counts 0..MAX while enabled, wraps
// to 0 after MAX, and flags the terminal count combinationally.
module serial_bit_counter #(
    parameter int MAX = 7,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          tc
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc    = (count_q == CW'(MAX));
    assign count = count_q;

    // Next count: clear wins over enable, wrap to zero after the terminal count
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (tc) begin
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out front end of the serial shift chain. Takes a WIDTH-bit
// word over valid/ready and emits it one bit per clock on dout, with gapless
// back-to-back frames when a new word is offered on the final-bit cycle.
// Optional feature macro PISO_PARITY_EN: appends one even-parity bit after the
// data bits and moves dout_last onto it.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [CNT_W-1:0] bit_cnt;
    logic             cnt_tc;
    logic             final_bit;
    logic             accept;

    // bit_cnt is the frame index of the bit currently on dout
    serial_bit_counter #(
        .MAX (FRAME_LEN - 1),
        .CW  (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_q == SHIFT),
        .count  (bit_cnt),
        .tc     (cnt_tc)
    );

    // A word may only be taken when idle or while the last bit is leaving,
    // which is what allows gapless back-to-back frames.
    assign final_bit  = (state_q == SHIFT) && cnt_tc;
    assign load_ready = (state_q == IDLE) || final_bit;
    assign accept     = load_valid && load_ready;

    // Next-state and next-output logic; the line parks low whenever no bit is live
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d     = parity_q;
`endif
        if (accept) begin
            // First bit goes straight to dout; the rest waits in the shift register
            state_d      = SHIFT;
            dout_valid_d = 1'b1;
            if (MSB_FIRST != 0) begin
                dout_d  = load_data[WIDTH-1];
                shreg_d = load_data << 1;
            end else begin
                dout_d  = load_data[0];
                shreg_d = load_data >> 1;
            end
`ifdef PISO_PARITY_EN
            parity_d = even_parity(PARITY_MAX_W'(load_data));
`endif
        end else if (state_q == SHIFT && !cnt_tc) begin
            dout_valid_d = 1'b1;
            dout_last_d  = (bit_cnt == CNT_W'(FRAME_LEN - 2));
`ifdef PISO_PARITY_EN
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                dout_d = parity_q;
            end else
`endif
            begin
                if (MSB_FIRST != 0) begin
                    dout_d  = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    dout_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
        end else if (state_q == SHIFT) begin
            // Final bit leaving with no follow-on word
            state_d = IDLE;
        end
    end

    // FSM state, shift register and registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: two instances (MSB-first and LSB-first) share
// the load interface. Directed table vectors cover the documented scenarios and
// a queue-based reference model checks every cycle, including random traffic.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             ready_m, dout_m, valid_m, last_m;
    logic             ready_l, dout_l, valid_l, last_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .load_data  (load_data),
        .dout       (dout_m),
        .dout_valid (valid_m),
        .dout_last  (last_m)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .load_data  (load_data),
        .dout       (dout_l),
        .dout_valid (valid_l),
        .dout_last  (last_l)
    );

    // Reference model: queue of bits still to appear on dout, one per cycle
    typedef struct {
        logic [WIDTH-1:0] word;
        int               idx;
    } bit_t;
    bit_t exp_q[$];

    // Directed vector: inputs for the cycle and outputs expected in that cycle
    typedef struct {
        logic             lv;
        logic [WIDTH-1:0] data;
        logic             dm;
        logic             dl;
        logic             v;
        logic             last;
        logic             rdy;
    } vec_t;
    vec_t tab[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic ref_bit(input logic [WIDTH-1:0] w, input int idx, input bit msb);
        if (idx >= WIDTH) return ^w;
        return msb ? w[WIDTH-1-idx] : w[idx];
    endfunction

    function automatic void add(input logic lv, input logic [WIDTH-1:0] d,
                                input logic dm, input logic dl, input logic v,
                                input logic l, input logic r);
        vec_t e;
        e.lv = lv; e.data = d; e.dm = dm; e.dl = dl; e.v = v; e.last = l; e.rdy = r;
        tab.push_back(e);
    endfunction

    function automatic vec_t mk(input logic lv, input logic [WIDTH-1:0] d);
        vec_t e;
        e.lv = lv; e.data = d; e.dm = 1'b0; e.dl = 1'b0; e.v = 1'b0; e.last = 1'b0; e.rdy = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model's view of the current cycle
    task automatic model_check();
        logic ev, edm, edl, el, er;
        if (exp_q.size() == 0) begin
            ev = 1'b0; edm = 1'b0; edl = 1'b0; el = 1'b0; er = 1'b1;
        end else begin
            ev  = 1'b1;
            edm = ref_bit(exp_q[0].word, exp_q[0].idx, 1'b1);
            edl = ref_bit(exp_q[0].word, exp_q[0].idx, 1'b0);
            el  = (exp_q[0].idx == FRAME_LEN - 1);
            er  = (exp_q.size() == 1);
        end
        check("model_dout_msb",  dout_m,  edm);
        check("model_dout_lsb",  dout_l,  edl);
        check("model_valid_msb", valid_m, ev);
        check("model_valid_lsb", valid_l, ev);
        check("model_last_msb",  last_m,  el);
        check("model_last_lsb",  last_l,  el);
        check("model_ready_msb", ready_m, er);
        check("model_ready_lsb", ready_l, er);
    endtask

    // Advance the model across a rising edge
    task automatic model_step();
        bit acc;
        acc = load_valid && (exp_q.size() <= 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                bit_t b;
                b.word = load_data;
                b.idx  = i;
                exp_q.push_back(b);
            end
            $display("accept word=%h t=%0t", load_data, $time);
        end
    endtask

    task automatic tick(input vec_t v, input bit use_tab);
        load_valid = v.lv;
        load_data  = v.data;
        @(negedge clk);
        model_check();
        if (use_tab) begin
            check("tab_dout_msb",  dout_m,  v.dm);
            check("tab_dout_lsb",  dout_l,  v.dl);
            check("tab_valid_msb", valid_m, v.v);
            check("tab_valid_lsb", valid_l, v.v);
            check("tab_last_msb",  last_m,  v.last);
            check("tab_last_lsb",  last_l,  v.last);
            check("tab_ready_msb", ready_m, v.rdy);
            check("tab_ready_lsb", ready_l, v.rdy);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

        // Idle: ten cycles parked low with ready high
        for (int i = 0; i < 10; i++) add(1'b0, WIDTH'($urandom), 0, 0, 0, 0, 1);
`ifndef PISO_PARITY_EN
        // A5 MSB/LSB, ignored pulse at frame cycle 3, 3C and 01 back-to-back
        add(1, 8'hA5, 0, 0, 0, 0, 1);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'h3C, 1, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'h01, 0, 0, 1, 1, 1);
        add(0, 8'h00, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 1, 1);
        // FF with a 00 pulse while busy: eight 1s regardless
        add(1, 8'hFF, 0, 0, 0, 0, 1);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(1, 8'h00, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1);
`else
        // 07 with even parity bit 1 appended; last on the ninth bit
        add(1, 8'h07, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_check();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tab[i]) tick(tab[i], 1'b1);

        // Reset mid-frame: outputs drop without waiting for a clock edge
        tick(mk(1'b1, 8'hA5), 1'b0);
        for (int i = 0; i < 3; i++) tick(mk(1'b0, 8'h00), 1'b0);
        check("prereset_valid", valid_m, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_dout_msb",  dout_m,  1'b0);
        check("rst_dout_lsb",  dout_l,  1'b0);
        check("rst_valid_msb", valid_m, 1'b0);
        check("rst_valid_lsb", valid_l, 1'b0);
        check("rst_last_msb",  last_m,  1'b0);
        check("rst_last_lsb",  last_l,  1'b0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        model_check();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(mk(1'b1, 8'h01), 1'b0);
        for (int i = 0; i < FRAME_LEN + 2; i++) tick(mk(1'b0, 8'h00), 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            tick(mk(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, WIDTH'($urandom)), 1'b0);
        end
        for (int i = 0; i < FRAME_LEN + 2; i++) tick(mk(1'b0, 8'h00), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
